// File: rtl/nn_neuron_seq_pkg.sv
// Shared types and arithmetic helpers for the neuron sequencer.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif

package nn_pkg;

  // Sequencer states, one neuron at a time
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    ACC,
    RESULT,
    OUT,
    DONE
  } nnState_e;

  // Drop fractional bits with an arithmetic shift, then clamp to the signed
  // range of a dataWidth-bit word. Works on a 64-bit sign-extended copy so
  // any accumulator width up to 64 can share it.
  function automatic logic signed [63:0] rescaleSat(
    input logic signed [63:0] acc,
    input int                 fracBits,
    input int                 dataWidth
  );
    logic signed [63:0] r;
    logic signed [63:0] maxV;
    logic signed [63:0] minV;
    r    = acc >>> fracBits;
    maxV = (64'sd1 <<< (dataWidth - 1)) - 64'sd1;
    minV = -(64'sd1 <<< (dataWidth - 1));
    if (r > maxV) begin
      r = maxV;
    end else if (r < minV) begin
      r = minV;
    end
    return r;
  endfunction

endpackage

// File: rtl/nn_neuron_seq_if.sv
// Memory read ports and result stream between the sequencer and its neighbours.
interface nn_neuron_seq_if #(
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int ACCUM_WIDTH = `ACC_WIDTH,
  parameter int IN_AW       = 8,
  parameter int N_AW        = 6
);
  logic [IN_AW-1:0]      act_addr;
  logic [DATA_WIDTH-1:0] act_rdata;
  logic [IN_AW+N_AW-1:0] wgt_addr;
  logic [DATA_WIDTH-1:0] wgt_rdata;
  logic [N_AW-1:0]       bias_addr;
  logic [ACCUM_WIDTH-1:0] bias_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [N_AW-1:0]       out_idx;

  modport master (
    output act_addr, wgt_addr, bias_addr, out_valid, out_data, out_idx,
    input  act_rdata, wgt_rdata, bias_rdata, out_ready
  );

  modport slave (
    input  act_addr, wgt_addr, bias_addr, out_valid, out_data, out_idx,
    output act_rdata, wgt_rdata, bias_rdata, out_ready
  );
endinterface

// File: rtl/nn_neuron_seq_mac.sv
// Signed multiply-accumulate with bias preload and a rescaled, saturated view
// of the accumulator.
module nn_mac_unit
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int ACCUM_WIDTH = `ACC_WIDTH,
  parameter int FRAC_BITS   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear_accum_i,
  input  logic                          bias_enable_i,
  input  logic signed [ACCUM_WIDTH-1:0] bias_i,
  input  logic                          enable_i,
  input  logic signed [DATA_WIDTH-1:0]  a_i,
  input  logic signed [DATA_WIDTH-1:0]  b_i,
  output logic signed [DATA_WIDTH-1:0]  rescaled_o,
  output logic                          valid_o
);
  logic signed [ACCUM_WIDTH-1:0]  accum_q;
  logic signed [ACCUM_WIDTH-1:0]  accum_d;
  logic signed [2*DATA_WIDTH-1:0] product;
  logic                           valid_q;

  assign product = a_i * b_i;

  // Clear (optionally seeding the bias) takes priority over accumulation
  always_comb begin
    accum_d = accum_q;
    if (clear_accum_i) begin
      accum_d = bias_enable_i ? bias_i : '0;
    end else if (enable_i) begin
      accum_d = accum_q + ACCUM_WIDTH'(product);
    end
  end

  // Accumulator and one-cycle-delayed enable as a "sum updated" flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      accum_q <= '0;
      valid_q <= 1'b0;
    end else begin
      accum_q <= accum_d;
      valid_q <= enable_i;
    end
  end

  assign valid_o    = valid_q;
  assign rescaled_o = DATA_WIDTH'(rescaleSat(64'(accum_q), FRAC_BITS, DATA_WIDTH));

endmodule

// File: rtl/nn_neuron_seq.sv
// Fully-connected layer sequencer: walks neurons, streams activations and
// weights into one MAC, and emits rescaled results on a valid/ready stream.
module nn_neuron_seq
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int ACCUM_WIDTH = `ACC_WIDTH,
  parameter int FRAC_BITS   = 8,
  parameter int MAX_INPUTS  = 256,
  parameter int MAX_NEURONS = 64,
  localparam int IN_AW      = $clog2(MAX_INPUTS),
  localparam int N_AW       = $clog2(MAX_NEURONS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [IN_AW:0]   num_inputs_i,
  input  logic [N_AW:0]    num_neurons_i,
  input  logic             bias_en_i,
  input  logic             relu_en_i,
  nn_neuron_seq_if.master  bus,
  output logic             busy_o,
  output logic             done_o
);
  localparam int WA = IN_AW + N_AW;

  nnState_e state_q, state_d;

  logic [IN_AW:0]        numInputs_q, numInputs_d;
  logic [N_AW:0]         numNeurons_q, numNeurons_d;
  logic                  biasEn_q, biasEn_d;
  logic                  reluEn_q, reluEn_d;
  logic [IN_AW-1:0]      kIdx_q, kIdx_d;
  logic [N_AW-1:0]       neuronIdx_q, neuronIdx_d;
  logic [WA-1:0]         wbase_q, wbase_d;
  logic [DATA_WIDTH-1:0] outData_q, outData_d;
  logic [N_AW-1:0]       outIdx_q, outIdx_d;

  logic [IN_AW:0]        kNext;
  logic                  kLast;
  logic                  moreNeurons;
  logic [IN_AW-1:0]      actAddr;
  logic                  macClear;
  logic                  macBiasEn;
  logic                  macEnable;
  logic signed [DATA_WIDTH-1:0] macRescaled;

  assign kNext       = {1'b0, kIdx_q} + (IN_AW+1)'(1);
  assign kLast       = (kNext == numInputs_q);
  assign moreNeurons = ((N_AW+1)'(neuronIdx_q) + (N_AW+1)'(1)) < numNeurons_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one pass of LOAD/CLEAR/ACC/RESULT/OUT per neuron
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (num_neurons_i == '0) ? DONE : LOAD;
      LOAD:    state_d = CLEAR;
      CLEAR:   state_d = (numInputs_q == '0) ? RESULT : ACC;
      ACC:     if (kLast) state_d = RESULT;
      RESULT:  state_d = OUT;
      OUT:     if (bus.out_ready) state_d = moreNeurons ? LOAD : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: MAC control, read address for the next input, status flags
  always_comb begin
    macClear  = 1'b0;
    macBiasEn = 1'b0;
    macEnable = 1'b0;
    actAddr   = '0;
    case (state_q)
      CLEAR: begin
        macClear  = 1'b1;
        macBiasEn = biasEn_q;
      end
      ACC: begin
        macEnable = 1'b1;
        actAddr   = kLast ? kIdx_q : kNext[IN_AW-1:0];
      end
      default: ;
    endcase
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = outData_q;
  assign bus.out_idx   = outIdx_q;
  assign bus.act_addr  = actAddr;
  assign bus.wgt_addr  = wbase_q + WA'(actAddr);
  assign bus.bias_addr = neuronIdx_q;

  // Datapath next values: layer config latch, counters, result capture
  always_comb begin
    numInputs_d  = numInputs_q;
    numNeurons_d = numNeurons_q;
    biasEn_d     = biasEn_q;
    reluEn_d     = reluEn_q;
    kIdx_d       = kIdx_q;
    neuronIdx_d  = neuronIdx_q;
    wbase_d      = wbase_q;
    outData_d    = outData_q;
    outIdx_d     = outIdx_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          numInputs_d  = num_inputs_i;
          numNeurons_d = num_neurons_i;
          biasEn_d     = bias_en_i;
          reluEn_d     = relu_en_i;
          neuronIdx_d  = '0;
          wbase_d      = '0;
        end
      end
      LOAD:   kIdx_d = '0;
      ACC:    kIdx_d = kNext[IN_AW-1:0];
      RESULT: begin
        outData_d = (reluEn_q && macRescaled[DATA_WIDTH-1]) ? '0 : macRescaled;
        outIdx_d  = neuronIdx_q;
      end
      OUT: begin
        if (bus.out_ready && moreNeurons) begin
          neuronIdx_d = neuronIdx_q + N_AW'(1);
          wbase_d     = wbase_q + WA'(numInputs_q);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      numInputs_q  <= '0;
      numNeurons_q <= '0;
      biasEn_q     <= 1'b0;
      reluEn_q     <= 1'b0;
      kIdx_q       <= '0;
      neuronIdx_q  <= '0;
      wbase_q      <= '0;
      outData_q    <= '0;
      outIdx_q     <= '0;
    end else begin
      numInputs_q  <= numInputs_d;
      numNeurons_q <= numNeurons_d;
      biasEn_q     <= biasEn_d;
      reluEn_q     <= reluEn_d;
      kIdx_q       <= kIdx_d;
      neuronIdx_q  <= neuronIdx_d;
      wbase_q      <= wbase_d;
      outData_q    <= outData_d;
      outIdx_q     <= outIdx_d;
    end
  end

  nn_mac_unit #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ACCUM_WIDTH (ACCUM_WIDTH),
    .FRAC_BITS   (FRAC_BITS)
  ) uMac (
    .clk           (clk),
    .rst_n         (~rst),
    .clear_accum_i (macClear),
    .bias_enable_i (macBiasEn),
    .bias_i        ($signed(bus.bias_rdata)),
    .enable_i      (macEnable),
    .a_i           ($signed(bus.act_rdata)),
    .b_i           ($signed(bus.wgt_rdata)),
    .rescaled_o    (macRescaled),
    .valid_o       ()
  );

endmodule

// File: tb/tb_nn_neuron_seq.sv
// Self-checking bench for nn_neuron_seq: table vectors, random layers against
// a behavioural model, backpressure, zero counts, busy start and mid-run reset.
module tb_nn_neuron_seq;
  localparam int DW    = 8;
  localparam int AW    = 32;
  localparam int FRAC  = 8;
  localparam int NACT  = 256;
  localparam int NWGT  = 16384;
  localparam int NBIAS = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [8:0] numInputs = '0;
  logic [6:0] numNeurons = '0;
  logic       biasEn = 1'b0;
  logic       reluEn = 1'b0;
  logic       outReady = 1'b1;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0] actMem [NACT];
  logic signed [DW-1:0] wgtMem [NWGT];
  logic signed [AW-1:0] biasMem [NBIAS];

  nn_neuron_seq_if #(.DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .IN_AW(8), .N_AW(6)) bus ();

  nn_neuron_seq #(
    .DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .FRAC_BITS(FRAC),
    .MAX_INPUTS(256), .MAX_NEURONS(64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .num_inputs_i  (numInputs),
    .num_neurons_i (numNeurons),
    .bias_en_i     (biasEn),
    .relu_en_i     (reluEn),
    .bus           (bus),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  assign bus.out_ready = outReady;

  // Synchronous-read layer buffers: data follows the address by one cycle
  always @(posedge clk) begin
    bus.act_rdata  <= actMem[bus.act_addr];
    bus.wgt_rdata  <= wgtMem[bus.wgt_addr];
    bus.bias_rdata <= biasMem[bus.bias_addr];
  end

  typedef struct {
    int nIn; int nNeu; bit bEn; bit rEn;
    int actV; int wgtV; int biasV; int expData;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference neuron: dot product plus bias, floor-divide by 2^FRAC, clamp, ReLU
  function automatic int modelOut(int n, int nIn, bit bEn, bit rEn);
    longint acc;
    longint r;
    longint div;
    div = longint'(1) << FRAC;
    acc = bEn ? longint'(biasMem[n]) : 0;
    for (int k = 0; k < nIn; k++) acc += longint'(actMem[k]) * longint'(wgtMem[n*nIn + k]);
    if (acc >= 0) r = acc / div;
    else r = -((-acc + div - 1) / div);
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    if (rEn && r < 0) r = 0;
    return int'(r);
  endfunction

  task automatic fillUniform(input int a, input int w, input int b);
    for (int i = 0; i < NACT; i++) actMem[i] = DW'(a);
    for (int i = 0; i < NWGT; i++) wgtMem[i] = DW'(w);
    for (int i = 0; i < NBIAS; i++) biasMem[i] = AW'(b);
  endtask

  task automatic fillRandom();
    for (int i = 0; i < NACT; i++) actMem[i] = DW'(int'($urandom_range(0, 255)) - 128);
    for (int i = 0; i < 512; i++) wgtMem[i] = DW'(int'($urandom_range(0, 255)) - 128);
    for (int i = 0; i < NBIAS; i++) biasMem[i] = AW'(int'($urandom_range(0, 10000)) - 5000);
  endtask

  // Pulse start for one edge with a config, then scramble the config inputs
  task automatic applyStimulus(input int nIn, input int nNeu, input bit bEn, input bit rEn);
    @(negedge clk);
    numInputs  = 9'(nIn);
    numNeurons = 7'(nNeu);
    biasEn     = bEn;
    reluEn     = rEn;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    numInputs  = 9'($urandom_range(0, 256));
    numNeurons = 7'($urandom_range(0, 64));
    biasEn     = 1'($urandom_range(0, 1));
    reluEn     = 1'($urandom_range(0, 1));
  endtask

  task automatic runLayer(input int nIn, input int nNeu, input bit bEn, input bit rEn,
                          input int stallN, input int stallCyc, input bit pokeStart,
                          output int firstData, output int firstLatency);
    int got;
    int cyc;
    int lo;
    int hi;
    bit stalled;
    bit stableOk;
    logic [DW-1:0] heldData;
    logic [5:0] heldIdx;
    got = 0; cyc = 0; lo = 1 << 30; hi = -1; stalled = 0;
    firstData = 0; firstLatency = -1;
    outReady = 1'b1;
    applyStimulus(nIn, nNeu, bEn, rEn);
    while (got < nNeu && cyc < 4000) begin
      if (busy) begin
        if (int'(bus.wgt_addr) < lo) lo = int'(bus.wgt_addr);
        if (int'(bus.wgt_addr) > hi) hi = int'(bus.wgt_addr);
      end
      if (pokeStart && cyc == 3) begin
        start = 1'b1;
        numNeurons = 7'd5;
      end else begin
        start = 1'b0;
      end
      if (bus.out_valid) begin
        if (firstLatency < 0) firstLatency = cyc;
        if (got == stallN && !stalled) begin
          stalled = 1; stableOk = 1;
          heldData = bus.out_data; heldIdx = bus.out_idx;
          outReady = 1'b0;
          for (int s = 0; s < stallCyc; s++) begin
            @(negedge clk); cyc++;
            if (!bus.out_valid || bus.out_data !== heldData || bus.out_idx !== heldIdx) stableOk = 0;
          end
          checkOutput("stallHold", longint'(stableOk), 1);
          outReady = 1'b1;
        end
        checkOutput($sformatf("data[%0d]", got), longint'($signed(bus.out_data)), modelOut(got, nIn, bEn, rEn));
        checkOutput($sformatf("idx[%0d]", got), longint'(bus.out_idx), got);
        if (nIn > 0) begin
          checkOutput($sformatf("wgtLo[%0d]", got), lo, got * nIn);
          checkOutput($sformatf("wgtHi[%0d]", got), hi, got * nIn + nIn - 1);
        end
        if (got == 0) firstData = int'($signed(bus.out_data));
        got++;
        lo = 1 << 30; hi = -1;
      end
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    if (got < nNeu) begin
      checkOutput("resultTimeout", got, nNeu);
    end else begin
      checkOutput("donePulse", longint'(done), 1);
      @(negedge clk);
      checkOutput("doneLow", longint'(done), 0);
      checkOutput("idleAfter", longint'(busy), 0);
    end
  endtask

  initial begin
    int fd;
    int lat;
    int nIn;
    int nNeu;
    bit seenDone;
    bit seenValid;

    vecs[0] = '{4, 1, 1'b0, 1'b0, 32, 16, 0, 8};
    vecs[1] = '{4, 1, 1'b1, 1'b0, 32, 16, 256, 9};
    vecs[2] = '{4, 1, 1'b0, 1'b0, 127, 127, 0, 127};
    vecs[3] = '{4, 1, 1'b0, 1'b0, 32, -16, 0, -8};
    vecs[4] = '{4, 1, 1'b0, 1'b1, 32, -16, 0, 0};
    vecs[5] = '{0, 1, 1'b1, 1'b0, 5, 5, 512, 2};
    vecs[6] = '{0, 1, 1'b0, 1'b0, 5, 5, 512, 0};
    vecs[7] = '{4, 1, 1'b0, 1'b0, -128, 127, 0, -128};

    fillUniform(0, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", longint'(busy), 0);
    checkOutput("rstDone", longint'(done), 0);
    checkOutput("rstValid", longint'(bus.out_valid), 0);
    checkOutput("rstData", longint'(bus.out_data), 0);
    checkOutput("rstIdx", longint'(bus.out_idx), 0);
    checkOutput("rstWgtAddr", longint'(bus.wgt_addr), 0);
    checkOutput("rstActAddr", longint'(bus.act_addr), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      fillUniform(vecs[i].actV, vecs[i].wgtV, vecs[i].biasV);
      runLayer(vecs[i].nIn, vecs[i].nNeu, vecs[i].bEn, vecs[i].rEn, -1, 0, 1'b0, fd, lat);
      checkOutput($sformatf("vec%0d", i), fd, vecs[i].expData);
      if (i == 0) checkOutput("firstValidLatency", lat, 7);
    end

    fillRandom();
    runLayer(5, 3, 1'b1, 1'b0, 1, 10, 1'b0, fd, lat);

    runLayer(3, 2, 1'b0, 1'b0, -1, 0, 1'b1, fd, lat);

    seenDone = 0; seenValid = 0;
    applyStimulus(4, 0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      if (done) seenDone = 1;
      if (bus.out_valid) seenValid = 1;
      @(negedge clk);
    end
    checkOutput("zeroNeuronDone", longint'(seenDone), 1);
    checkOutput("zeroNeuronNoValid", longint'(seenValid), 0);
    checkOutput("zeroNeuronIdle", longint'(busy), 0);

    for (int r = 0; r < 6; r++) begin
      fillRandom();
      nIn  = int'($urandom_range(0, 12));
      nNeu = int'($urandom_range(1, 4));
      runLayer(nIn, nNeu, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), 3, 1'b0, fd, lat);
    end

    fillRandom();
    applyStimulus(8, 2, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstBusy", longint'(busy), 0);
    checkOutput("midRstValid", longint'(bus.out_valid), 0);
    checkOutput("midRstDone", longint'(done), 0);
    checkOutput("midRstWgtAddr", longint'(bus.wgt_addr), 0);
    rst = 1'b0;
    runLayer(8, 2, 1'b1, 1'b1, -1, 0, 1'b0, fd, lat);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
